// File: rtl/lif_ring_network.sv
// lif_ring_network: N leaky integrate-and-fire neurons in a unidirectional ring.
// Neuron i is driven by the registered spike of neuron (i-1) mod N through
// a programmable weight w[i]. Refractory periods plus the one-cycle synaptic
// hop let a single injected spike circulate.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   ena                   update enable; 0 freezes state and clears spikes
//   threshold             shared firing threshold
//   ext_stim[N]           per-neuron bias current enable
//   cfg_we/addr/data      weight write port (w[cfg_addr] <= cfg_data)
//   spike_out[N]          registered one-cycle spike pulses
//   spike_any             registered OR of the spikes
//   spike_count           wrapping count of neuron-0 spikes
//
// Optional macro LIF_INHIBIT_EN: weights become two's-complement signed
// (inhibitory when negative) and the membrane clamps at 0 from below.

module lif_neuron #(
    parameter int V_WIDTH        = 8,
    parameter int W_WIDTH        = 8,
    parameter int LEAK_SHIFT     = 3,
    parameter int BIAS           = 16,
    parameter int REFRACT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [V_WIDTH-1:0] threshold,
    input  logic               stim,
    input  logic               pre,
    input  logic [W_WIDTH-1:0] weight,
    output logic               fire,
    output logic               spike
);
    localparam int RC_W = $clog2(REFRACT_CYCLES + 1);

    typedef enum logic {INTEGRATE, REFRACT} state_t;

    state_t             state, state_next;
    logic [V_WIDTH-1:0] v, v_next, v_sat, leak;
    logic [RC_W-1:0]    rcnt, rcnt_next;

    assign leak = v >> LEAK_SHIFT;

`ifdef LIF_INHIBIT_EN
    // Extra headroom bit so the sign survives; arithmetic is modular, the
    // top bit tells us the result went negative.
    localparam int SUM_W = V_WIDTH + 3;
    logic [SUM_W-1:0] sum;
    always_comb begin
        sum = {3'b000, v} - {3'b000, leak}
            + (stim ? SUM_W'(BIAS) : SUM_W'(0))
            + (pre ? SUM_W'($signed(weight)) : SUM_W'(0));
        if (sum[SUM_W-1])
            v_sat = '0;
        else if (|sum[SUM_W-2:V_WIDTH])
            v_sat = '1;
        else
            v_sat = sum[V_WIDTH-1:0];
    end
`else
    localparam int SUM_W = V_WIDTH + 2;
    logic [SUM_W-1:0] sum;
    always_comb begin
        sum = {2'b00, v} - {2'b00, leak}
            + (stim ? SUM_W'(BIAS) : SUM_W'(0))
            + (pre ? SUM_W'(weight) : SUM_W'(0));
        v_sat = (|sum[SUM_W-1:V_WIDTH]) ? '1 : sum[V_WIDTH-1:0];
    end
`endif

    always_comb begin
        state_next = state;
        v_next     = v;
        rcnt_next  = rcnt;
        fire       = 1'b0;
        if (ena) begin
            case (state)
                INTEGRATE: begin
                    if (v_sat >= threshold) begin
                        fire       = 1'b1;
                        v_next     = '0;
                        rcnt_next  = RC_W'(REFRACT_CYCLES);
                        state_next = REFRACT;
                    end else begin
                        v_next = v_sat;
                    end
                end
                REFRACT: begin
                    v_next    = '0;
                    rcnt_next = rcnt - 1'b1;
                    // Last ignored edge; the following edge integrates.
                    if (rcnt == RC_W'(1))
                        state_next = INTEGRATE;
                end
                default: state_next = INTEGRATE;
            endcase
        end
    end

    // fire is already gated by ena, so a disabled edge clears the spike.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INTEGRATE;
            v     <= '0;
            rcnt  <= '0;
            spike <= 1'b0;
        end else begin
            state <= state_next;
            v     <= v_next;
            rcnt  <= rcnt_next;
            spike <= fire;
        end
    end
endmodule

module lif_ring_network #(
    parameter int N_NEURONS      = 4,
    parameter int V_WIDTH        = 8,
    parameter int W_WIDTH        = 8,
    parameter int LEAK_SHIFT     = 3,
    parameter int BIAS           = 16,
    parameter int REFRACT_CYCLES = 2,
    parameter int WEIGHT_INIT    = 0,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [V_WIDTH-1:0]   threshold,
    input  logic [N_NEURONS-1:0] ext_stim,
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_addr,
    input  logic [W_WIDTH-1:0]   cfg_data,
    output logic [N_NEURONS-1:0] spike_out,
    output logic                 spike_any,
    output logic [CNT_WIDTH-1:0] spike_count
);
    logic [N_NEURONS-1:0][W_WIDTH-1:0] w;
    logic [N_NEURONS-1:0]              fire;

    // Writes ignore ena; out-of-range addresses match no entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++)
                w[i] <= W_WIDTH'(WEIGHT_INIT);
        end else begin
            for (int i = 0; i < N_NEURONS; i++)
                if (cfg_we && cfg_addr == 3'(i))
                    w[i] <= cfg_data;
        end
    end

    for (genvar i = 0; i < N_NEURONS; i++) begin : g_neuron
        lif_neuron #(
            .V_WIDTH       (V_WIDTH),
            .W_WIDTH       (W_WIDTH),
            .LEAK_SHIFT    (LEAK_SHIFT),
            .BIAS          (BIAS),
            .REFRACT_CYCLES(REFRACT_CYCLES)
        ) u_neuron (
            .clk      (clk),
            .rst_n    (rst_n),
            .ena      (ena),
            .threshold(threshold),
            .stim     (ext_stim[i]),
            .pre      (spike_out[(i + N_NEURONS - 1) % N_NEURONS]),
            .weight   (w[i]),
            .fire     (fire[i]),
            .spike    (spike_out[i])
        );
    end

    // Derived from this edge's fire decisions so it lines up with spike_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_any   <= 1'b0;
            spike_count <= '0;
        end else begin
            spike_any   <= |fire;
            spike_count <= spike_count + CNT_WIDTH'(fire[0]);
        end
    end
endmodule

// File: tb/tb_lif_ring_network.sv
module tb_lif_ring_network;
    logic        clk = 1'b0;
    logic        rst_n, ena, cfg_we;
    logic [7:0]  threshold, cfg_data;
    logic [3:0]  ext_stim, spike_out;
    logic [2:0]  cfg_addr;
    logic        spike_any;
    logic [15:0] spike_count;

    // Second instance: long refractory period and large bias.
    logic        rst_n_b, ena_b, cfg_we_b;
    logic [7:0]  threshold_b, cfg_data_b;
    logic [3:0]  ext_stim_b, spike_out_b;
    logic [2:0]  cfg_addr_b;
    logic        spike_any_b;
    logic [15:0] spike_count_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lif_ring_network dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .threshold(threshold),
        .ext_stim(ext_stim), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .spike_out(spike_out), .spike_any(spike_any),
        .spike_count(spike_count)
    );

    lif_ring_network #(.BIAS(200), .REFRACT_CYCLES(4)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .ena(ena_b), .threshold(threshold_b),
        .ext_stim(ext_stim_b), .cfg_we(cfg_we_b), .cfg_addr(cfg_addr_b),
        .cfg_data(cfg_data_b), .spike_out(spike_out_b), .spike_any(spike_any_b),
        .spike_count(spike_count_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a;
        rst_n = 1'b0; ena = 1'b1; ext_stim = 4'h0; threshold = 8'd64;
        cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 8'd0;
        tick; tick;
        rst_n = 1'b1;
    endtask

    task automatic reset_b;
        rst_n_b = 1'b0; ena_b = 1'b1; ext_stim_b = 4'h0; threshold_b = 8'd64;
        cfg_we_b = 1'b0; cfg_addr_b = 3'd0; cfg_data_b = 8'd0;
        tick; tick;
        rst_n_b = 1'b1;
    endtask

    // Load weight 64 everywhere, stimulate neuron 0 until it fires, then stop.
    task automatic start_ring;
        int n;
        reset_a;
        for (int i = 0; i < 4; i++) begin
            cfg_we = 1'b1; cfg_addr = 3'(i); cfg_data = 8'd64;
            tick;
        end
        cfg_we = 1'b0;
        ext_stim = 4'b0001;
        n = 0;
        while (spike_out[0] !== 1'b1 && n < 10) begin
            tick;
            n++;
        end
        ext_stim = 4'b0000;
        checks++;
        if (n !== 5) begin
            failures++;
            $display("FAIL ring_start edges=%0d expected=5", n);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ena = 1'b1; ext_stim = 4'hF; threshold = 8'd0;
        cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 8'd0;
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++;
            if (spike_out !== 4'h0 || spike_any !== 1'b0 || spike_count !== 16'd0) begin
                failures++;
                $display("FAIL reset_hold k=%0d spike_out=%b any=%b cnt=%0d expected 0/0/0",
                         k, spike_out, spike_any, spike_count);
            end
        end
        rst_n = 1'b1;
        // threshold 0: every integrating neuron fires on the first edge
        tick;
        checks++;
        if (spike_out !== 4'hF || spike_any !== 1'b1 || spike_count !== 16'd1) begin
            failures++;
            $display("FAIL reset_first_edge spike_out=%b any=%b cnt=%0d expected 1111/1/1",
                     spike_out, spike_any, spike_count);
        end
        tick;
        checks++;
        if (spike_out !== 4'h0 || spike_any !== 1'b0) begin
            failures++;
            $display("FAIL reset_refract spike_out=%b any=%b expected 0000/0", spike_out, spike_any);
        end
    endtask

    task automatic test_single_neuron;
        int exp_v[4] = '{16, 30, 43, 54};
        reset_a;
        ext_stim = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            tick;
            checks++;
            if (spike_out !== 4'h0 || dut_a.g_neuron[0].u_neuron.v !== 8'(exp_v[k])) begin
                failures++;
                $display("FAIL single_integrate k=%0d spike_out=%b v=%0d expected 0000 v=%0d",
                         k, spike_out, dut_a.g_neuron[0].u_neuron.v, exp_v[k]);
            end
        end
        tick;
        checks++;
        if (spike_out !== 4'b0001 || spike_count !== 16'd1) begin
            failures++;
            $display("FAIL single_fire1 spike_out=%b cnt=%0d expected 0001/1", spike_out, spike_count);
        end
        for (int k = 0; k < 6; k++) begin
            tick;
            checks++;
            if (spike_out !== 4'h0) begin
                failures++;
                $display("FAIL single_gap k=%0d spike_out=%b expected 0000", k, spike_out);
            end
        end
        tick;
        checks++;
        if (spike_out !== 4'b0001 || spike_count !== 16'd2) begin
            failures++;
            $display("FAIL single_fire2 spike_out=%b cnt=%0d expected 0001/2", spike_out, spike_count);
        end
        ext_stim = 4'b0000;
    endtask

    task automatic test_enable_gating;
        reset_a;
        ext_stim = 4'b0001;
        tick; tick;                 // v = 30
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick;
            checks++;
            if (spike_out !== 4'h0 || dut_a.g_neuron[0].u_neuron.v !== 8'd30) begin
                failures++;
                $display("FAIL ena_hold k=%0d spike_out=%b v=%0d expected 0000 v=30",
                         k, spike_out, dut_a.g_neuron[0].u_neuron.v);
            end
        end
        ena = 1'b1;
        tick; tick;                 // 43, 54
        tick;
        checks++;
        if (spike_out !== 4'b0001 || spike_count !== 16'd1) begin
            failures++;
            $display("FAIL ena_resume spike_out=%b cnt=%0d expected 0001/1", spike_out, spike_count);
        end
        ext_stim = 4'b0000;
        // Gating in the middle of an oscillation clears the outputs.
        start_ring;
        tick; tick;
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick;
            checks++;
            if (spike_out !== 4'h0 || spike_any !== 1'b0) begin
                failures++;
                $display("FAIL ena_ring_low k=%0d spike_out=%b any=%b expected 0000/0",
                         k, spike_out, spike_any);
            end
        end
        ena = 1'b1;
    endtask

    task automatic test_ring;
        logic [3:0] e;
        start_ring;
        for (int k = 1; k <= 12; k++) begin
            tick;
            e = 4'(1 << (k % 4));
            checks++;
            if (spike_out !== e || spike_any !== 1'b1) begin
                failures++;
                $display("FAIL ring_march k=%0d spike_out=%b any=%b expected %b/1",
                         k, spike_out, spike_any, e);
            end
        end
    endtask

    task automatic test_config;
        logic [3:0] e;
        logic [3:0] tail[7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        start_ring;
        // Out-of-range write must not disturb any weight.
        cfg_we = 1'b1; cfg_addr = 3'd6; cfg_data = 8'd0;
        for (int k = 1; k <= 8; k++) begin
            tick;
            cfg_we = 1'b0;
            e = 4'(1 << (k % 4));
            checks++;
            if (spike_out !== e) begin
                failures++;
                $display("FAIL cfg_addr6 k=%0d spike_out=%b expected %b", k, spike_out, e);
            end
        end
        // Zero w[1]: the hop in flight still uses the old weight.
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 8'd0;
        for (int k = 0; k < 7; k++) begin
            tick;
            cfg_we = 1'b0;
            checks++;
            if (spike_out !== tail[k]) begin
                failures++;
                $display("FAIL cfg_w1 k=%0d spike_out=%b expected %b", k, spike_out, tail[k]);
            end
        end
    endtask

    task automatic test_saturation;
        reset_b;
        threshold_b = 8'd255;
        ext_stim_b = 4'b0001;
        tick;                       // v = 200
        checks++;
        if (spike_out_b !== 4'h0) begin
            failures++;
            $display("FAIL sat_first spike_out=%b expected 0000", spike_out_b);
        end
        tick;                       // 200-25+200 = 375 -> 255 fires
        checks++;
        if (spike_out_b !== 4'b0001 || spike_count_b !== 16'd1) begin
            failures++;
            $display("FAIL sat_fire spike_out=%b cnt=%0d expected 0001/1", spike_out_b, spike_count_b);
        end
        ext_stim_b = 4'b0000;
    endtask

    task automatic test_refract4;
        logic [3:0] seq[8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0000, 4'b0000, 4'b0000, 4'b0000};
        reset_b;
        for (int i = 0; i < 4; i++) begin
            cfg_we_b = 1'b1; cfg_addr_b = 3'(i); cfg_data_b = 8'd64;
            tick;
        end
        cfg_we_b = 1'b0;
        ext_stim_b = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            tick;
            ext_stim_b = 4'b0000;
            checks++;
            if (spike_out_b !== seq[k]) begin
                failures++;
                $display("FAIL refract4 k=%0d spike_out=%b expected %b", k, spike_out_b, seq[k]);
            end
        end
    endtask

`ifdef LIF_INHIBIT_EN
    task automatic test_inhibit;
        reset_a;
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 8'h80;   // -128 into neuron 1
        tick;
        cfg_we = 1'b0;
        ext_stim = 4'b0001;
        tick; tick;                 // v0 = 30
        ext_stim = 4'b0011;
        tick; tick; tick;           // v0 fires, v1 = 43
        checks++;
        if (spike_out !== 4'b0001) begin
            failures++;
            $display("FAIL inhibit_pre spike_out=%b expected 0001", spike_out);
        end
        tick;                       // 43-5+16-128 < 0 -> 0
        checks++;
        if (dut_a.g_neuron[1].u_neuron.v !== 8'd0 || spike_out[1] !== 1'b0) begin
            failures++;
            $display("FAIL inhibit_clamp v1=%0d spike1=%b expected 0/0",
                     dut_a.g_neuron[1].u_neuron.v, spike_out[1]);
        end
        ext_stim = 4'b0000;
    endtask
`endif

    initial begin
        rst_n_b = 1'b0; ena_b = 1'b1; ext_stim_b = 4'h0; threshold_b = 8'd64;
        cfg_we_b = 1'b0; cfg_addr_b = 3'd0; cfg_data_b = 8'd0;
        test_reset;
        test_single_neuron;
        test_enable_gating;
        test_ring;
        test_config;
        test_saturation;
        test_refract4;
`ifdef LIF_INHIBIT_EN
        test_inhibit;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lif_ring_network.md
Name: lif_ring_network

Overview:
- Parametrised successor to the fixed two-neuron/two-synapse oscillator top.
- N leaky integrate-and-fire neurons coupled in a unidirectional ring through programmable synaptic weights.
- Neuron i receives the registered spike of neuron (i-1) mod N. Refractory periods and one-cycle synaptic delay let the ring sustain oscillation.
- Instantiated under the tt_um top level; spike vector drives uo_out.

Parameters:
- N_NEURONS, 4, number of neurons in the ring (2..8).
- V_WIDTH, 8, membrane potential width, unsigned.
- W_WIDTH, 8, synaptic weight width.
- LEAK_SHIFT, 3, leak = v >> LEAK_SHIFT per update.
- BIAS, 16, current added when ext_stim[i]=1.
- REFRACT_CYCLES, 2, enabled cycles a neuron ignores input after spiking (>=1).
- WEIGHT_INIT, 0, reset value of every weight.
- CNT_WIDTH, 16, spike counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  update enable; 0 freezes all state.
- threshold  in  V_WIDTH  firing threshold, shared by all neurons.
- ext_stim  in  N_NEURONS  per-neuron bias enable.
- cfg_we  in  1  weight write strobe.
- cfg_addr  in  3  weight index (synapse into neuron cfg_addr).
- cfg_data  in  W_WIDTH  weight value.
- spike_out  out  N_NEURONS  registered one-cycle spike pulses.
- spike_any  out  1  registered OR of spike_out.
- spike_count  out  CNT_WIDTH  count of neuron-0 spikes, wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (async assert, sync release):
  - v[i]=0, w[i]=WEIGHT_INIT, spike_out=0, spike_any=0, spike_count=0.
  - All neurons in INTEGRATE; refractory counters = 0.
- Per-neuron FSM, evaluated each rising edge with ena=1:
  - INTEGRATE:
    - I = (ext_stim[i] ? BIAS : 0) + (spike_out[(i-1) mod N] ? w[i] : 0).
    - v_next = v - (v >> LEAK_SHIFT) + I.
    - Computed in V_WIDTH+2 bits, saturated to 2^V_WIDTH-1.
    - If v_next >= threshold: spike_out[i]<=1, v<=0, rcnt<=REFRACT_CYCLES, go REFRACT.
    - Otherwise: v<=v_next, spike_out[i]<=0.
  - REFRACT:
    - spike_out[i]<=0, v held 0, inputs ignored, rcnt decrements.
    - When rcnt reaches 0, return to INTEGRATE; next edge integrates.
    - Net effect: a spike at edge t means edges t+1..t+REFRACT_CYCLES are ignored and integration resumes at t+REFRACT_CYCLES+1.
- Latency:
  - Synapse hop is exactly one cycle: spike_out[i-1] high after edge t can fire neuron i at edge t+1.
  - spike_any follows the spike_out update on the same edge (computed from v_next decisions).
- threshold=0: every INTEGRATE edge fires.
- Saturation:
  - v clamps at 2^V_WIDTH-1.
  - If threshold = 2^V_WIDTH-1, a saturated neuron fires.
- ena=0:
  - v, rcnt, FSM, weights and counter held.
  - spike_out and spike_any forced to 0 on the next edge.
  - No update occurs; resuming ena continues from the held state.
- Config writes:
  - cfg_we=1 writes w[cfg_addr]<=cfg_data on that edge regardless of ena.
  - The new weight is used from the following edge.
  - cfg_addr >= N_NEURONS: write ignored, no state change.
- spike_count increments on each edge where spike_out[0] is set to 1.
- Mid-operation reset: all state returns to reset values immediately; no spike emitted.

Optional Feature:
- Macro LIF_INHIBIT_EN.
- Defined:
  - Weights are two's-complement signed W_WIDTH; negative weights are inhibitory.
  - Sum computed signed; v_next clamps at 0 from below and 2^V_WIDTH-1 from above.
- Undefined:
  - Weights unsigned, no inhibition, lower clamp logic absent.

Test Plan:
- Reset: hold rst_n=0 with ena=1 and ext_stim=all ones -> spike_out=0, spike_count=0, no spikes during reset; first spike no earlier than the 1st edge after release.
- Single-neuron integration: defaults, weights 0, threshold=64, ext_stim=0001.
  - v follows 16, 30, 43, 54, then fires on the 5th enabled edge.
  - Neuron 0 ignores input for 2 edges, resumes from v=0, and spikes again 7 edges after the first spike.
  - spike_count=2.
- Ring oscillation: all weights=64, threshold=64, ext_stim=0001 for one cycle only.
  - Spikes march 0->1->2->3->0 one hop per cycle, sustained with period 4.
  - spike_any continuously 1 after the first spike.
  - With REFRACT_CYCLES=4, the wave dies after neuron 3.
- Enable gating: during ring oscillation drop ena for 5 cycles -> spike_out=0 while low; on re-enable the pattern resumes from the held state.
- Config: write cfg_addr=1, cfg_data=0 mid-oscillation -> propagation stops at neuron 1 from the next hop; a write to cfg_addr=6 changes nothing.
- Saturation/inhibit:
  - BIAS=200, threshold=255, ext_stim=0001 -> v clamps at 255 and fires.
  - With LIF_INHIBIT_EN, weight -128 into a neuron at v=50 -> v=0, no underflow.
